// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, frame width and controller states.
package uart_pkg;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    localparam int FRAME_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // 8 data bits with two stop bits cannot fit in an 11-bit frame
    function automatic logic cfg_illegal(input logic data_len, input logic stop);
        return data_len & stop;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and emits a
// registered one-cycle tick in the cycle after the terminal count.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_term;

    assign w_term = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign o_tick = r_tick;

    // Count bit-period cycles; the tick is registered so the shifter acts one
    // cycle after the counter hits its terminal value
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_en) begin
            r_tick <= w_term;
            r_cnt  <= w_term ? '0 : r_cnt + CW'(1);
        end else begin
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit controller: accepts a byte plus line config, drives the
// Framer inputs, captures the 11-bit frame and serialises it onto tx.
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_LAT    = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_tx_data,
    input  logic               i_tx_valid,
    output logic               o_tx_ready,
    input  logic [1:0]         i_cfg_parity,
    input  logic               i_cfg_data_len,
    input  logic               i_cfg_stop,
    output logic [7:0]         o_frm_din,
    output logic [1:0]         o_frm_parity,
    output logic               o_frm_data_len,
    output logic               o_frm_stop,
    output logic               o_frm_rst_n,
    input  logic [FRAME_W-1:0] i_frm_frame,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done,
    output logic               o_cfg_err
);
    localparam int LW = (FRAME_LAT > 1) ? $clog2(FRAME_LAT) : 1;

    state_t             r_state;
    logic [FRAME_W-1:0] r_shreg;
    logic [3:0]         r_bit_cnt;
    logic [LW-1:0]      r_lat_cnt;
    logic               r_tx;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_cfg_err;
    logic [7:0]         r_frm_din;
    logic [1:0]         r_frm_parity;
    logic               r_frm_data_len;
    logic               r_frm_stop;
    logic               r_frm_rst_n;
    logic               w_tick;
    logic               w_illegal;

    assign w_illegal = cfg_illegal(i_cfg_data_len, i_cfg_stop);

    // Baud counter is held clear through LOAD so it starts at zero on SHIFT entry
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (r_state == LOAD),
        .i_en  (r_state == SHIFT),
        .o_tick(w_tick)
    );

    // Transmit sequencer: IDLE accepts, LOAD waits on the Framer, SHIFT serialises
    always_ff @(posedge i_clk) begin
        r_frm_rst_n <= ~i_rst;
        r_done      <= 1'b0;
        r_cfg_err   <= 1'b0;
        if (i_rst) begin
            r_state        <= IDLE;
            r_tx           <= 1'b1;
            r_ready        <= 1'b0;
            r_busy         <= 1'b0;
            r_shreg        <= '1;
            r_bit_cnt      <= '0;
            r_lat_cnt      <= '0;
            r_frm_din      <= '0;
            r_frm_parity   <= '0;
            r_frm_data_len <= 1'b0;
            r_frm_stop     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    if (i_tx_valid && r_ready) begin
                        r_frm_din      <= i_tx_data;
                        r_frm_parity   <= i_cfg_parity;
                        r_frm_data_len <= i_cfg_data_len;
                        // A 12-bit request is trimmed to one stop bit
                        r_frm_stop     <= i_cfg_stop & ~w_illegal;
                        r_cfg_err      <= w_illegal;
                        r_ready        <= 1'b0;
                        r_busy         <= 1'b1;
                        r_lat_cnt      <= '0;
                        r_state        <= LOAD;
                    end
                end
                LOAD: begin
                    r_tx <= 1'b1;
                    if (r_lat_cnt == LW'(FRAME_LAT - 1)) begin
                        r_shreg   <= i_frm_frame;
                        r_bit_cnt <= '0;
                        r_state   <= SHIFT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LW'(1);
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 4'd10) begin
                            r_tx    <= 1'b1;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            // tx takes the bit that becomes shreg[0] at this edge
                            r_shreg   <= {1'b1, r_shreg[FRAME_W-1:1]};
                            r_tx      <= r_shreg[1];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_tx <= r_shreg[0];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_tx_ready     = r_ready;
    assign o_tx           = r_tx;
    assign o_tx_busy      = r_busy;
    assign o_tx_done      = r_done;
    assign o_cfg_err      = r_cfg_err;
    assign o_frm_din      = r_frm_din;
    assign o_frm_parity   = r_frm_parity;
    assign o_frm_data_len = r_frm_data_len;
    assign o_frm_stop     = r_frm_stop;
    assign o_frm_rst_n    = r_frm_rst_n;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Scoreboard bench for uart_tx_controller with a behavioural Framer model.
module tb_uart_tx_controller;
    localparam int CPB    = 4;
    localparam int LAT    = 1;
    localparam int START  = LAT + 1;
    localparam int DONE   = START + 11 * CPB;

    typedef struct {
        logic [10:0] frame;
        logic        err;
        logic [7:0]  din;
        logic [1:0]  par;
        logic        len;
        logic        stop;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  cfg_parity;
    logic        cfg_data_len;
    logic        cfg_stop;
    logic [7:0]  frm_din;
    logic [1:0]  frm_parity;
    logic        frm_data_len;
    logic        frm_stop;
    logic        frm_rst_n;
    logic [10:0] frm_frame;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;
    logic        cfg_err;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_active = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    uart_tx_controller #(.CLKS_PER_BIT(CPB), .FRAME_LAT(LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .i_cfg_parity(cfg_parity), .i_cfg_data_len(cfg_data_len),
        .i_cfg_stop(cfg_stop), .o_frm_din(frm_din), .o_frm_parity(frm_parity),
        .o_frm_data_len(frm_data_len), .o_frm_stop(frm_stop), .o_frm_rst_n(frm_rst_n),
        .i_frm_frame(frm_frame), .o_tx(tx), .o_tx_busy(tx_busy), .o_tx_done(tx_done),
        .o_cfg_err(cfg_err)
    );

    // Frame as the line should carry it: start 0, data LSB first, optional
    // parity, then stop/pad bits which are all 1
    function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic [1:0] par,
                                              input logic len);
        logic [10:0] f;
        logic        pb;
        int          n;
        int          p;
        f  = '1;
        f[0] = 1'b0;
        p  = 1;
        pb = 1'b0;
        n  = len ? 8 : 7;
        for (int i = 0; i < n; i++) begin
            f[p[3:0]] = d[i];
            pb = pb ^ d[i];
            p = p + 1;
        end
        if (par == 2'b01) f[p[3:0]] = ~pb;
        else if (par == 2'b10) f[p[3:0]] = pb;
        return f;
    endfunction

    // Framer model driven by the controller's registered frm_* outputs
    always_comb frm_frame = ref_frame(frm_din, frm_parity, frm_data_len);

    function automatic exp_t mk_exp(input logic [7:0] d, input logic [1:0] p,
                                    input logic l, input logic s, input int t);
        exp_t e;
        e.din   = d;
        e.par   = p;
        e.len   = l;
        e.stop  = s & ~l;
        e.err   = l & s;
        e.frame = ref_frame(d, p, l);
        e.t     = t;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Cycle count and accept logging: each accept pushes its expected frame
    initial begin : logger
        forever begin
            @(posedge clk);
            if (!rst && tx_valid && tx_ready)
                sb.push_back(mk_exp(tx_data, cfg_parity, cfg_data_len, cfg_stop, cyc + 1));
            cyc = cyc + 1;
        end
    end

    // Monitor: follows the head frame cycle by cycle, pops it on tx_done
    initial begin : monitor
        exp_t cur;
        int   rel;
        int   bi;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                mon_active = 0;
            end else begin
                if (!mon_active && sb.size() > 0) begin
                    cur = sb[0];
                    mon_active = 1;
                end
                if (mon_active) begin
                    rel = cyc - cur.t;
                    if (rel == 0) begin
                        chk("cfg_err", 32'(cfg_err), 32'(cur.err));
                        chk("frm_din", 32'(frm_din), 32'(cur.din));
                        chk("frm_parity", 32'(frm_parity), 32'(cur.par));
                        chk("frm_data_len", 32'(frm_data_len), 32'(cur.len));
                        chk("frm_stop", 32'(frm_stop), 32'(cur.stop));
                        chk("ready_load", 32'(tx_ready), 32'd0);
                    end else begin
                        chk("cfg_err_quiet", 32'(cfg_err), 32'd0);
                    end
                    if (rel < DONE) begin
                        chk("busy", 32'(tx_busy), 32'd1);
                        chk("done_early", 32'(tx_done), 32'd0);
                        if (rel < START) begin
                            chk("tx_pre", 32'(tx), 32'd1);
                        end else begin
                            bi = (rel - START) / CPB;
                            chk("tx_bit", 32'(tx), 32'(cur.frame[bi[3:0]]));
                        end
                    end else begin
                        chk("tx_done", 32'(tx_done), 32'd1);
                        chk("tx_end", 32'(tx), 32'd1);
                        chk("ready_end", 32'(tx_ready), 32'd1);
                        chk("busy_end", 32'(tx_busy), 32'd0);
                        void'(sb.pop_front());
                        mon_active = 0;
                    end
                end else begin
                    chk("idle_done", 32'(tx_done), 32'd0);
                    chk("idle_tx", 32'(tx), 32'd1);
                    chk("idle_cfg_err", 32'(cfg_err), 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] p, input logic l,
                        input logic s, input bit keep, output int t);
        int n;
        t = -1;
        tx_data = d; cfg_parity = p; cfg_data_len = l; cfg_stop = s;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 500) begin
            step();
            n++;
        end
        if (!tx_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: tx_ready stayed 0 for %0d cycles", n);
        end else begin
            step();
            t = cyc;
        end
        if (!keep) begin
            tx_valid = 1'b0;
            tx_data = 8'($urandom);
            cfg_parity = 2'($urandom);
            cfg_data_len = 1'($urandom);
            cfg_stop = 1'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_active) && n < 3000) begin
            step();
            n++;
        end
        n_chk++;
        if (sb.size() != 0 || mon_active) begin
            n_fail++;
            $display("FAIL idle_timeout: %0d frames pending after %0d cycles", sb.size(), n);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t1, t2, t5;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
        cfg_parity = '0; cfg_data_len = 1'b0; cfg_stop = 1'b0;
        step(); step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_frm", 32'({frm_din, frm_parity, frm_data_len, frm_stop}), 32'd0);
        chk("rst_frm_rst_n", 32'(frm_rst_n), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(tx_ready), 32'd1);
        chk("post_rst_frm_rst_n", 32'(frm_rst_n), 32'd1);

        // Long idle with no valid
        for (int i = 0; i < 100; i++) begin
            step();
            if (i % 10 == 0) begin
                chk("idle_ready", 32'(tx_ready), 32'd1);
                chk("idle_frm", 32'({frm_din, frm_parity, frm_data_len, frm_stop}), 32'd0);
            end
        end

        // Directed frames
        send(8'hAB, 2'b01, 1'b0, 1'b1, 1'b0, t1); wait_idle();
        send(8'h6D, 2'b00, 1'b1, 1'b0, 1'b0, t1); wait_idle();
        send(8'hFF, 2'b10, 1'b1, 1'b1, 1'b0, t1); wait_idle();

        // Back-to-back with valid held; second accept lands right after tx_done
        send(8'h00, 2'b01, 1'b1, 1'b0, 1'b1, t1);
        send(8'hFF, 2'b10, 1'b0, 1'b1, 1'b0, t2);
        chk("b2b_gap", 32'(t2 - t1), 32'(DONE + 1));
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 7; j++) step();
            tx_valid = 1'b1;
            chk("ignore_valid_ready", 32'(tx_ready), 32'd0);
            step();
            tx_valid = 1'b0;
        end
        wait_idle();

        // Reset during the fifth bit discards the frame
        send(8'($urandom), 2'($urandom), 1'b1, 1'b0, 1'b0, t5);
        while (cyc < t5 + START + 4 * CPB + 1) step();
        rst = 1'b1;
        step();
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(tx_busy), 32'd0);
        chk("midrst_frm_rst_n", 32'(frm_rst_n), 32'd0);
        chk("midrst_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        step();
        chk("midrst_frm_rst_n_rel", 32'(frm_rst_n), 32'd1);
        chk("midrst_ready", 32'(tx_ready), 32'd1);
        for (int j = 0; j < 60; j++) step();
        send(8'h5A, 2'b01, 1'b1, 1'b0, 1'b0, t5); wait_idle();

        // Randomised frames, including illegal configs and back-to-back gaps
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b0, t1);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) step();
        end
        wait_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_controller.md
Name: uart_tx_controller

Overview:
- Sequences the transmit Framer: accepts a byte and line configuration over a valid/ready handshake, then drives and latches the Framer inputs.
- Captures the 11-bit frame the Framer produces and serialises it onto the tx line at a baud rate set by an internal divider.
- Sits between the host-side transmit interface and the UART pin, with the Framer as its combinational datapath.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=2).
- FRAME_LAT, 1, cycles held in LOAD before the Framer output is sampled (>=1).
- FRAME_W, 11, frame width produced by the Framer. Fixed at 11; not to be overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  host has a byte plus config.
- tx_ready  out  1  controller can accept.
- cfg_parity  in  2  00 none, 01 odd, 10 even, 11 none.
- cfg_data_len  in  1  0 = 7-bit data, 1 = 8-bit data.
- cfg_stop  in  1  0 = 1 stop bit, 1 = 2 stop bits.
- frm_din  out  8  to Framer Din.
- frm_parity  out  2  to Framer parity select.
- frm_data_len  out  1  to Framer data-length select.
- frm_stop  out  1  to Framer stop select.
- frm_rst_n  out  1  Framer reset, active-low.
- frm_frame  in  11  frame from the Framer; bit0 is transmitted first; unused positions are 1.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  high in LOAD or SHIFT.
- tx_done  out  1  one-cycle pulse when the last bit period ends.
- cfg_err  out  1  one-cycle pulse on an accepted illegal config.

Behaviour:
- Reset values (while rst is high, and one cycle after it falls):
  - state = IDLE, tx = 1, tx_ready = 0 during rst and 1 after.
  - tx_busy = 0, tx_done = 0, cfg_err = 0.
  - frm_din = 0, frm_parity = 0, frm_data_len = 0, frm_stop = 0.
  - frm_rst_n = ~rst, registered.
- States: IDLE -> LOAD -> SHIFT -> IDLE.
- IDLE:
  - tx_ready = 1, tx = 1.
  - An accept is tx_valid & tx_ready at a rising edge. On accept, register tx_data and the cfg fields onto the frm_* outputs and enter LOAD.
  - tx_data and cfg may change freely after the accept.
- Illegal config (cfg_data_len = 1 with cfg_stop = 1) would need 12 bits:
  - Drive frm_stop = 0.
  - Pulse cfg_err in the first LOAD cycle.
  - The frame is still sent.
- LOAD:
  - tx_ready = 0, tx = 1.
  - A cycle counter runs for FRAME_LAT cycles.
  - On the last LOAD cycle, capture frm_frame into an 11-bit shift register, clear the bit counter and baud counter, and enter SHIFT.
- SHIFT:
  - tx = shreg[0], registered, so no glitches.
  - The baud counter counts 0..CLKS_PER_BIT-1. At terminal count: shift right, fill the MSB with 1, increment the bit counter.
  - After 11 bit periods (bit counter = 10 at terminal count): go to IDLE, pulse tx_done, tx = 1.
- Timing:
  - tx_done is asserted in the first IDLE cycle, and tx_ready is 1 in that same cycle, so back-to-back frames are allowed.
  - Accept to first start-bit cycle on tx = FRAME_LAT + 1 cycles.
  - Frame duration = 11*CLKS_PER_BIT cycles.
- tx_valid during LOAD or SHIFT is ignored; it is not queued.
- frm_* outputs hold their values until the next accept.
- Reset mid-frame (rst asserted in any state):
  - Next cycle: IDLE, tx = 1, counters cleared, frm_rst_n = 0.
  - No tx_done pulse; the in-flight frame is discarded.
- Counter widths: $clog2(CLKS_PER_BIT) for the baud counter, 4 bits for the bit counter. Counters never wrap past their terminal values.

Decomposition:
- Shared package uart_pkg:
  - Parity encodings PAR_NONE = 2'b00, PAR_ODD = 2'b01, PAR_EVEN = 2'b10, PAR_NONE2 = 2'b11.
  - FRAME_W = 11.
  - State enum {IDLE, LOAD, SHIFT}.
- One sub-module: uart_baud_gen, the CLKS_PER_BIT counter with clear and terminal-count pulse.
- The Framer is instantiated alongside the controller at the transmitter top, not inside it.

Test Plan (CLKS_PER_BIT = 4, FRAME_LAT = 1, real Framer attached):
1. tx_data = 0xAB, parity 01, data_len 0, stop 1, accepted at cycle T.
   -> Start bit appears at T+2.
   -> tx sequence 0,1,1,0,1,0,1,0,1,1,1, each bit 4 cycles.
   -> tx_done at T+46; tx_ready returns in the same cycle.
2. tx_data = 0x6D, parity 00, data_len 1, stop 0.
   -> tx = 0,1,0,1,1,0,1,1,0,1,1 (no parity, final pad bit 1).
   -> cfg_err = 0.
3. tx_data = 0xFF, data_len 1, stop 1, parity 10.
   -> cfg_err pulses once; frm_stop = 0.
   -> tx = 0,1,1,1,1,1,1,1,1,0,1.
4. Hold tx_valid high with 0x00 then 0xFF.
   -> Two frames back-to-back; second accepted in the tx_done cycle.
   -> tx_valid pulses during SHIFT are ignored.
5. Assert rst for 1 cycle during the 5th bit.
   -> Next cycle: tx = 1, tx_busy = 0, frm_rst_n = 0 for 1 cycle, no tx_done.
   -> A new accept afterwards yields a complete, correct frame.
6. tx_valid = 0 for 100 cycles after reset.
   -> tx stays 1, tx_ready = 1, frm_* stay 0.
